// File: rtl/kf_pkg.sv
// kf_pkg: shared widths, FSM encoding and fixed-point helpers for the Kalman filter stages.
package kf_pkg;
    localparam int N_DEF    = 20;
    localparam int FRAC_DEF = 10;
    localparam logic signed [N_DEF-1:0] ONE = N_DEF'(1 << FRAC_DEF);

    // M states share 01xx and U states 10xx so the low bits give the element index
    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_DONE = 4'd1,
        S_M0   = 4'd4,
        S_M1   = 4'd5,
        S_M2   = 4'd6,
        S_M3   = 4'd7,
        S_U0   = 4'd8,
        S_U1   = 4'd9,
        S_U2   = 4'd10,
        S_U3   = 4'd11
    } state_t;

    function automatic logic signed [63:0] sat_n(input logic signed [63:0] x, input int w);
        logic signed [63:0] hi, lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        return x > hi ? hi : x < lo ? lo : x;
    endfunction
endpackage

// File: rtl/fx_mac2.sv
// fx_mac2: saturating Q(FRAC) two-product sum, (a*b + c*d) >>> FRAC clamped to N bits.
module fx_mac2
    import kf_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int FRAC = FRAC_DEF
) (
    input  logic signed [N-1:0] a,
    input  logic signed [N-1:0] b,
    input  logic signed [N-1:0] c,
    input  logic signed [N-1:0] d,
    output logic signed [N-1:0] y
);
    localparam int W = 2 * N + 1;
    logic signed [W-1:0] sum, sh;
    assign sum = W'(a) * W'(b) + W'(c) * W'(d);
    assign sh  = sum >>> FRAC;
    assign y   = N'(sat_n(64'(sh), N));
endmodule

// File: rtl/post_cov_semipar.sv
// post_cov_semipar: posterior covariance P_PRIOR - K*(H*P_PRIOR) on 2x2 Q(FRAC) matrices,
// one shared two-multiplier MAC stepped through eight compute cycles.
module post_cov_semipar
    import kf_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int FRAC = FRAC_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic signed [N-1:0] k00,
    input  logic signed [N-1:0] k01,
    input  logic signed [N-1:0] k10,
    input  logic signed [N-1:0] k11,
    input  logic signed [N-1:0] h00,
    input  logic signed [N-1:0] h01,
    input  logic signed [N-1:0] h10,
    input  logic signed [N-1:0] h11,
    input  logic signed [N-1:0] pp00,
    input  logic signed [N-1:0] pp01,
    input  logic signed [N-1:0] pp10,
    input  logic signed [N-1:0] pp11,
    output logic                busy,
    output logic                done,
    output logic signed [N-1:0] P_POST00,
    output logic signed [N-1:0] P_POST01,
    output logic signed [N-1:0] P_POST10,
    output logic signed [N-1:0] P_POST11
);
    state_t state, state_nxt;
    logic signed [N-1:0] kr [4];
    logic signed [N-1:0] hr [4];
    logic signed [N-1:0] pr [4];
    logic signed [N-1:0] m [4];
    logic signed [N-1:0] post [4];
    logic signed [N-1:0] a, b, c, d, y;
    logic signed [N:0]   diff;
    logic [1:0]          idx;
    logic                is_m, is_u, idle, accept;

    assign idx    = state[1:0];
    assign is_m   = state[3:2] == 2'b01;
    assign is_u   = state[3];
    assign idle   = state == S_IDLE || state == S_DONE;
    assign accept = idle && start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = idle ? (start ? S_M0 : S_IDLE) : state == S_U3 ? S_DONE : state_t'(state + 4'd1);
    end

    // Row r = idx[1], column c = idx[0]; M phase uses H,P_PRIOR and U phase uses K,M
    always_comb begin
        a = is_u ? kr[{idx[1], 1'b0}] : hr[{idx[1], 1'b0}];
        c = is_u ? kr[{idx[1], 1'b1}] : hr[{idx[1], 1'b1}];
        b = is_u ? m[{1'b0, idx[0]}] : pr[{1'b0, idx[0]}];
        d = is_u ? m[{1'b1, idx[0]}] : pr[{1'b1, idx[0]}];
    end

    fx_mac2 #(.N(N), .FRAC(FRAC)) u_mac (
        .a(a),
        .b(b),
        .c(c),
        .d(d),
        .y(y)
    );

    assign diff = {pr[idx][N-1], pr[idx]} - {y[N-1], y};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kr   <= '{default: '0};
            hr   <= '{default: '0};
            pr   <= '{default: '0};
            m    <= '{default: '0};
            post <= '{default: '0};
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            if (accept) begin
                kr <= '{k00, k01, k10, k11};
                hr <= '{h00, h01, h10, h11};
                pr <= '{pp00, pp01, pp10, pp11};
            end
            if (is_m) m[idx] <= y;
            if (is_u) post[idx] <= N'(sat_n(64'(diff), N));
            busy <= accept || (busy && state != S_U3);
            done <= state == S_U3;
        end
    end

    assign P_POST00 = post[0];
    assign P_POST01 = post[1];
    assign P_POST10 = post[2];
    assign P_POST11 = post[3];
endmodule

// File: tb/tb_post_cov_semipar.sv
// tb_post_cov_semipar: directed and randomized checks of post_cov_semipar against a
// matrix-level model of P_PRIOR - K*(H*P_PRIOR) with saturating Q(FRAC) arithmetic.
module tb_post_cov_semipar;
    import kf_pkg::*;
    localparam int N = N_DEF;
    localparam int FRAC = FRAC_DEF;
    localparam longint MAXV = (longint'(1) <<< (N - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (N - 1));

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic signed [N-1:0] k00, k01, k10, k11, h00, h01, h10, h11, pp00, pp01, pp10, pp11;
    logic busy, done;
    logic signed [N-1:0] P_POST00, P_POST01, P_POST10, P_POST11;

    post_cov_semipar dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .k00(k00), .k01(k01), .k10(k10), .k11(k11),
        .h00(h00), .h01(h01), .h10(h10), .h11(h11),
        .pp00(pp00), .pp01(pp01), .pp10(pp10), .pp11(pp11),
        .busy(busy), .done(done),
        .P_POST00(P_POST00), .P_POST01(P_POST01), .P_POST10(P_POST10), .P_POST11(P_POST11)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int kk[4], hh[4], pp[4], expv[4], obs[4];
    int done_at;
    bit busy_ok, busy_end, done_after;

    int d_k[5][4] = '{'{0, 0, 0, 0}, '{512, 0, 0, 512}, '{1024, 0, 0, 1024},
                      '{-1024, 0, 0, -1024}, '{512, 0, 0, 512}};
    int d_p[5][4] = '{'{1280, 0, 0, 1280}, '{1280, 0, 0, 1280}, '{1024, 256, 256, 512},
                      '{524287, 0, 0, 0}, '{-1, 0, 0, 0}};
    int d_e[5][4] = '{'{1280, 0, 0, 1280}, '{640, 0, 0, 640}, '{0, 0, 0, 0},
                      '{524287, 0, 0, 0}, '{0, 0, 0, 0}};

    function automatic longint sat(input longint x);
        return x > MAXV ? MAXV : x < MINV ? MINV : x;
    endfunction

    // Matrix-level reference: M = H*P, KM = K*M, P_POST = P - KM, each step clamped
    task automatic model();
        longint mm[4];
        longint km;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
                mm[2*r+c] = sat((longint'(hh[2*r]) * pp[c] + longint'(hh[2*r+1]) * pp[2+c]) >>> FRAC);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) begin
                km = sat((longint'(kk[2*r]) * mm[c] + longint'(kk[2*r+1]) * mm[2+c]) >>> FRAC);
                expv[2*r+c] = int'(sat(longint'(pp[2*r+c]) - km));
            end
    endtask

    function automatic int rnd(input bit full);
        return full ? int'($urandom_range(0, (1 << N) - 1)) - (1 << (N - 1))
                    : int'($urandom_range(0, 4095)) - 2048;
    endfunction

    task automatic apply();
        k00 = kk[0][N-1:0]; k01 = kk[1][N-1:0]; k10 = kk[2][N-1:0]; k11 = kk[3][N-1:0];
        h00 = hh[0][N-1:0]; h01 = hh[1][N-1:0]; h10 = hh[2][N-1:0]; h11 = hh[3][N-1:0];
        pp00 = pp[0][N-1:0]; pp01 = pp[1][N-1:0]; pp10 = pp[2][N-1:0]; pp11 = pp[3][N-1:0];
    endtask

    task automatic scramble();
        {k00, k01, k10, k11} = {$urandom, $urandom, $urandom};
        {h00, h01, h10, h11} = {$urandom, $urandom, $urandom};
        {pp00, pp01, pp10, pp11} = {$urandom, $urandom, $urandom};
    endtask

    task automatic grab();
        obs[0] = int'(P_POST00); obs[1] = int'(P_POST01);
        obs[2] = int'(P_POST10); obs[3] = int'(P_POST11);
    endtask

    task automatic set_scenario(input int s);
        kk = d_k[s];
        hh = '{1024, 0, 0, 1024};
        pp = d_p[s];
    endtask

    // One accepted operation; inputs are scrambled after the accept edge
    task automatic run_op();
        @(negedge clk);
        apply();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        scramble();
        busy_ok = busy === 1'b1 && done === 1'b0;
        done_at = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) begin
                done_at = n;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        busy_end = busy;
        grab();
        @(posedge clk);
        @(negedge clk);
        done_after = done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        grab();
        tests++;
        if ({done, busy} !== 2'b00) begin
            fails++;
            $display("FAIL reset_flags: done/busy=%b expected 00", {done, busy});
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (obs[i] !== 0) begin
                fails++;
                $display("FAIL reset_p%0d: got %0d expected 0", i, obs[i]);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        for (int s = 0; s < 5; s++) begin
            set_scenario(s);
            run_op();
            tests++;
            if (done_at !== 8) begin
                fails++;
                $display("FAIL dir%0d_done_at: got %0d expected 8", s + 1, done_at);
            end
            tests++;
            if (!busy_ok || busy_end !== 1'b0 || done_after !== 1'b0) begin
                fails++;
                $display("FAIL dir%0d_handshake: busy_ok=%0d busy_at_done=%0d done_next=%0d expected 1,0,0",
                         s + 1, busy_ok, busy_end, done_after);
            end
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (obs[i] !== d_e[s][i]) begin
                    fails++;
                    $display("FAIL dir%0d_p%0d: got %0d expected %0d", s + 1, i, obs[i], d_e[s][i]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 30; t++) begin
            int mode = int'($urandom_range(0, 2));
            for (int i = 0; i < 4; i++) begin
                kk[i] = rnd(mode == 0 || (mode == 2 && $urandom_range(0, 1) == 1));
                hh[i] = rnd(mode == 0 || (mode == 2 && $urandom_range(0, 1) == 1));
                pp[i] = rnd(mode == 0 || (mode == 2 && $urandom_range(0, 1) == 1));
            end
            model();
            run_op();
            tests++;
            if (done_at !== 8) begin
                fails++;
                $display("FAIL rnd%0d_done_at: got %0d expected 8", t, done_at);
            end
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (obs[i] !== expv[i]) begin
                    fails++;
                    $display("FAIL rnd%0d_p%0d: got %0d expected %0d", t, i, obs[i], expv[i]);
                end
            end
        end
    endtask

    task automatic test_retrigger();
        int ndone = 0, first = -1;
        set_scenario(1);
        @(negedge clk);
        apply();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 2) start = 1'b1;
            if (n == 3) start = 1'b0;
            if (done === 1'b1) begin
                ndone++;
                if (first < 0) first = n;
            end
        end
        tests++;
        if (ndone !== 1 || first !== 8) begin
            fails++;
            $display("FAIL retrigger: %0d dones first at %0d, expected 1 done at 8", ndone, first);
        end
        grab();
        tests++;
        if (obs[0] !== 640 || obs[3] !== 640) begin
            fails++;
            $display("FAIL retrigger_result: got %0d,%0d expected 640,640", obs[0], obs[3]);
        end
    endtask

    task automatic test_back_to_back();
        int q[$];
        for (int i = 0; i < 4; i++) begin
            kk[i] = rnd(1'b0);
            hh[i] = rnd(1'b0);
            pp[i] = rnd(1'b0);
        end
        model();
        @(negedge clk);
        apply();
        start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 38; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 26) start = 1'b0;
            if (done === 1'b1) begin
                q.push_back(n);
                grab();
                for (int i = 0; i < 4; i++) begin
                    tests++;
                    if (obs[i] !== expv[i]) begin
                        fails++;
                        $display("FAIL b2b_at%0d_p%0d: got %0d expected %0d", n, i, obs[i], expv[i]);
                    end
                end
            end
        end
        tests++;
        if (q.size() != 3 || q[0] != 8 || q[1] != 17 || q[2] != 26) begin
            fails++;
            $display("FAIL b2b_done_edges: got %p expected '{8, 17, 26}", q);
        end
    endtask

    task automatic test_reset_midop();
        set_scenario(2);
        @(negedge clk);
        apply();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        grab();
        tests++;
        if ({done, busy} !== 2'b00 || obs[0] !== 0 || obs[1] !== 0 || obs[2] !== 0 || obs[3] !== 0) begin
            fails++;
            $display("FAIL midop_reset: done/busy=%b P=%0d,%0d,%0d,%0d expected 00 and zeros",
                     {done, busy}, obs[0], obs[1], obs[2], obs[3]);
        end
        begin
            bit seen = 1'b0;
            repeat (10) begin
                @(posedge clk);
                @(negedge clk);
                if (done === 1'b1) seen = 1'b1;
            end
            tests++;
            if (seen) begin
                fails++;
                $display("FAIL midop_no_done: got done during reset expected none");
            end
        end
        rst_n = 1'b1;
        set_scenario(1);
        run_op();
        tests++;
        if (done_at !== 8 || obs[0] !== 640 || obs[1] !== 0 || obs[2] !== 0 || obs[3] !== 640) begin
            fails++;
            $display("FAIL midop_rerun: done_at=%0d P=%0d,%0d,%0d,%0d expected 8 and 640,0,0,640",
                     done_at, obs[0], obs[1], obs[2], obs[3]);
        end
    endtask

    initial begin
        scramble();
        test_reset();
        test_directed();
        test_random();
        test_retrigger();
        test_back_to_back();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
